// File: rtl/bram_sync_fifo.sv
// Single-clock FIFO on an inferred simple-dual-port block RAM with a fixed 2-cycle read latency.
// Define BRAM_SYNC_FIFO_STICKY_ERR_EN to make overflow/underflow sticky until reset.
module bram_sync_fifo #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 7,
  parameter int AFULL_TH   = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      din,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]         AFULL_C = CW'(AFULL_TH);
  localparam logic [CW-1:0]         CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q, afull_q;
  logic                  rd_s1_q, rd_s2_q;
  logic [WIDTH-1:0]      ram_q, dout_q;
  logic                  dout_valid_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // Handshake: a write is taken when wr_en=1 and the registered full flag is 0; a read
  // is taken when rd_en=1 and the registered empty flag is 0. Both decisions use the
  // pre-edge flags, so there is no combinational path from rd_en to write acceptance.
  always_comb begin
    wr_acc   = wr_en & ~full_q;
    rd_acc   = rd_en & ~empty_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
`ifdef BRAM_SYNC_FIFO_STICKY_ERR_EN
    ovf_d = ovf_q | (wr_en & full_q);
    unf_d = unf_q | (rd_en & empty_q);
`else
    ovf_d = wr_en & full_q;
    unf_d = rd_en & empty_q;
`endif
  end

  // RAM is never reset; read-first on a same-address write returns the old word,
  // which is the one still owed to the reader.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= din;
    if (rd_s1_q) ram_q <= mem_q[rd_addr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rd_addr_q    <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      rd_s1_q      <= 1'b0;
      rd_s2_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= (count_d == DEPTH_C);
      empty_q      <= (count_d == '0);
      afull_q      <= (count_d >= AFULL_C);
      if (rd_acc) rd_addr_q <= rd_ptr_q;
      rd_s1_q      <= rd_acc;
      rd_s2_q      <= rd_s1_q;
      if (rd_s2_q) dout_q <= ram_q;
      dout_valid_q <= rd_s2_q;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_bram_sync_fifo.sv
// Bench for bram_sync_fifo: queue-based reference model, per-cycle compare, directed
// corner cases and randomized traffic with occasional resets.
module tb_bram_sync_fifo;

  localparam int WIDTH      = 9;
  localparam int DEPTH_LOG2 = 7;
  localparam int AFULL_TH   = 120;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst;
  logic                wr_en;
  logic [WIDTH-1:0]    din;
  logic                rd_en;
  logic [WIDTH-1:0]    dout;
  logic                dout_valid;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;
  logic                underflow;

  bram_sync_fifo #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .AFULL_TH(AFULL_TH)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // reference model: stored words in order, plus reads in flight with their due cycle
  typedef struct {
    int               due;
    logic [WIDTH-1:0] data;
  } pend_t;

  logic [WIDTH-1:0] exp_q[$];
  pend_t            pend_q[$];
  pend_t            p;
  logic [WIDTH-1:0] exp_dout = '0;
  bit               exp_dv   = 1'b0;
  bit               exp_ovf  = 1'b0;
  bit               exp_unf  = 1'b0;
  bit               wa, ra;
  bit               started  = 1'b0;
  int               cyc      = 0;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      exp_dout = '0;
      exp_dv   = 1'b0;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
    end else begin
      wa = wr_en && (exp_q.size() < DEPTH);
      ra = rd_en && (exp_q.size() > 0);
      if (ra) begin
        p.due  = cyc + 2;
        p.data = exp_q.pop_front();
        pend_q.push_back(p);
      end
      if (wa) exp_q.push_back(din);
`ifdef BRAM_SYNC_FIFO_STICKY_ERR_EN
      exp_ovf = exp_ovf || (wr_en && !wa);
      exp_unf = exp_unf || (rd_en && !ra);
`else
      exp_ovf = wr_en && !wa;
      exp_unf = rd_en && !ra;
`endif
      exp_dv = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        exp_dout = pend_q[0].data;
        exp_dv   = 1'b1;
        void'(pend_q.pop_front());
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("count",       64'(count),       64'(exp_q.size()));
      check("full",        64'(full),        64'(exp_q.size() == DEPTH));
      check("empty",       64'(empty),       64'(exp_q.size() == 0));
      check("almost_full", 64'(almost_full), 64'(exp_q.size() >= AFULL_TH));
      check("dout_valid",  64'(dout_valid),  64'(exp_dv));
      check("dout",        64'(dout),        64'(exp_dout));
      check("overflow",    64'(overflow),    64'(exp_ovf));
      check("underflow",   64'(underflow),   64'(exp_unf));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    tick();
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_dout",  64'(dout),  64'd0);
    check("rst_dv",    64'(dout_valid), 64'd0);
    rst = 1'b0;

    // fill with 0x000..0x07F
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      din   = WIDTH'(i);
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
      check("fill_afull", 64'(almost_full), 64'((i + 1) >= AFULL_TH));
    end
    check("fill_full", 64'(full), 64'd1);

    // write into a full FIFO
    din = 9'h1FF;
    tick();
    wr_en = 1'b0;
    check("ovf_flag",  64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd128);

    // drain; word i appears after the edge two reads later
    for (int i = 0; i < DEPTH; i++) begin
      rd_en = 1'b1;
      tick();
      if (i >= 2) begin
        check("drain_dv",   64'(dout_valid), 64'd1);
        check("drain_dout", 64'(dout), 64'(i - 2));
      end
    end
    rd_en = 1'b0;
    tick();
    check("drain_dout_126", 64'(dout), 64'h07E);
    tick();
    check("drain_dout_127", 64'(dout), 64'h07F);
    tick();
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_dv_end", 64'(dout_valid), 64'd0);

    // read from an empty FIFO
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("unf_flag",  64'(underflow), 64'd1);
    check("unf_dv",    64'(dout_valid), 64'd0);
    check("unf_count", 64'(count), 64'd0);
    tick();
`ifdef BRAM_SYNC_FIFO_STICKY_ERR_EN
    check("unf_held", 64'(underflow), 64'd1);
`else
    check("unf_pulse", 64'(underflow), 64'd0);
`endif

    // write then read on the next edge
    wr_en = 1'b1; din = 9'h0AA;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    check("aa_dv_early", 64'(dout_valid), 64'd0);
    tick();
    check("aa_dv",   64'(dout_valid), 64'd1);
    check("aa_dout", 64'(dout), 64'h0AA);

    // hold at 64 entries with simultaneous traffic across pointer wraps
    for (int i = 0; i < 64; i++) begin
      wr_en = 1'b1;
      din   = WIDTH'($urandom_range(0, 511));
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'b1; rd_en = 1'b1;
      din   = WIDTH'($urandom_range(0, 511));
      tick();
    end
    idle();
    check("steady_count", 64'(count), 64'd64);
    tick();
    tick();

    // reads in flight when reset hits are discarded
    rd_en = 1'b1;
    tick();
    tick();
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_inflight_dv",    64'(dout_valid), 64'd0);
    check("rst_inflight_count", 64'(count), 64'd0);
    check("rst_inflight_empty", 64'(empty), 64'd1);
    check("rst_inflight_dout",  64'(dout), 64'd0);
    tick();
    check("rst_inflight_dv1", 64'(dout_valid), 64'd0);
    tick();
    check("rst_inflight_dv2", 64'(dout_valid), 64'd0);

    // randomized traffic, bias changes to visit full and empty
    for (int blk = 0; blk < 12; blk++) begin
      int wp, rp;
      wp = $urandom_range(10, 95);
      rp = $urandom_range(10, 95);
      for (int i = 0; i < 200; i++) begin
        rst   = ($urandom_range(0, 399) == 0);
        wr_en = ($urandom_range(0, 99) < wp);
        rd_en = ($urandom_range(0, 99) < rp);
        din   = WIDTH'($urandom_range(0, 511));
        tick();
      end
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_sync_fifo.md
BRAM_SYNC_FIFO -- requirements
Module: bram_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 9, data word width in bits (1..72).
REQ-002 SHALL have parameter DEPTH_LOG2, default 7, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (range 4..12).
REQ-003 SHALL have parameter AFULL_TH, default 120, almost-full threshold in entries (range 1..DEPTH).
REQ-004 SHALL have port clk, input, 1, single clock for all logic and memory.
REQ-005 SHALL have port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-006 SHALL have port wr_en, input, 1, write request.
REQ-007 SHALL have port din, input, WIDTH, write data.
REQ-008 SHALL have port rd_en, input, 1, read request.
REQ-009 SHALL have port dout, output, WIDTH, read data from the output register.
REQ-010 SHALL have port dout_valid, output, 1, dout holds a newly read word this cycle.
REQ-011 SHALL have port full, output, 1, no free entries.
REQ-012 SHALL have port empty, output, 1, no stored entries.
REQ-013 SHALL have port almost_full, output, 1, count >= AFULL_TH.
REQ-014 SHALL have port count, output, DEPTH_LOG2+1, number of stored entries (0..DEPTH).
REQ-015 SHALL have port overflow, output, 1, write rejected.
REQ-016 SHALL have port underflow, output, 1, read rejected.

Function
REQ-017 SHALL store data in an inferred simple-dual-port block RAM of DEPTH x WIDTH; all DEPTH entries usable.
REQ-018 SHALL accept a write when wr_en=1 and full=0: din stored at write pointer, pointer +1 mod DEPTH.
REQ-019 SHALL accept a read when rd_en=1 and empty=0: read pointer +1 mod DEPTH.
REQ-020 SHALL have fixed read latency 2: accepted read at edge N -> RAM read stage at N+1, output register loaded and dout_valid=1 after edge N+2, for one cycle per accepted read.
REQ-021 SHALL hold dout unchanged while dout_valid=0; back-to-back accepted reads yield back-to-back dout_valid.
REQ-022 SHALL register full, empty, almost_full, count; all update on the same edge as the pointers.
REQ-023 SHALL evaluate acceptance against pre-edge full/empty: full with wr_en&rd_en -> read accepted, write rejected, count -1; empty with both -> write accepted, read rejected, count +1; otherwise both accepted, count unchanged.
REQ-024 SHALL make a word written at edge N readable by a read accepted at edge N+1 or later, returning the new data.
REQ-025 SHALL ignore din on rejected writes and leave memory, pointers, count unchanged; rejected reads do not move pointers or assert dout_valid.
REQ-026 SHALL wrap pointers from DEPTH-1 to 0 without disturbing count or flags.

Reset
REQ-027 SHALL on rst=1 at a clock edge clear pointers and count to 0, set empty=1, full=0, almost_full=0, dout_valid=0, dout=0, overflow=0, underflow=0.
REQ-028 SHALL discard in-flight reads on reset: no dout_valid in the two cycles following reset even if reads preceded it.
REQ-029 SHALL ignore wr_en and rd_en while rst=1; memory contents are not cleared.

Configuration
REQ-030 SHALL with macro BRAM_SYNC_FIFO_STICKY_ERR_EN defined hold overflow/underflow at 1 from the first rejected write/read until rst.
REQ-031 SHALL without BRAM_SYNC_FIFO_STICKY_ERR_EN pulse overflow/underflow for exactly one cycle after each rejected write/read.

Verification (defaults WIDTH=9, DEPTH_LOG2=7, AFULL_TH=120)
REQ-032 SHALL cover: write 0x000..0x07F (128 words), then 128 reads -> full=1 after 128th write, almost_full=1 from count=120, dout sequence 0x000..0x07F each 2 cycles after its read, empty=1 at end.
REQ-033 SHALL cover: full FIFO, wr_en=1 din=0x1FF -> count stays 128, overflow asserts (pulse or sticky per macro), 0x1FF never read back.
REQ-034 SHALL cover: empty FIFO, rd_en=1 -> underflow asserts, dout_valid stays 0, count 0.
REQ-035 SHALL cover: write 0x0AA at edge N, rd_en at N+1 -> dout=0x0AA with dout_valid at N+3; simultaneous wr/rd at count=64 for 300 cycles -> count stays 64, pointers wrap, data order preserved.
REQ-036 SHALL cover: 3 reads accepted then rst at next edge -> no dout_valid afterwards, count=0, empty=1, dout=0.
